// File: rtl/spike_window_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_decoder_pkg
// Purpose  : State encoding and helper functions for the spike window decoder.
// Revision : 1.0
// ============================================================================
package spike_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Index width for n classes; a single class still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_window_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : spike_window_decoder_if
// Purpose  : Control, spike and result-handshake bundle of the decoder.
// Revision : 1.0
// ============================================================================
interface spike_window_decoder_if
    import spike_decoder_pkg::*;
#(
    parameter int N_NEURONS = 2,
    parameter int CNT_W     = 8,
    parameter int WIN_W     = 16
) ();
    localparam int c_IDX_W = idx_width(N_NEURONS);

    logic                       start;
    logic [WIN_W-1:0]           window_len;
    logic [N_NEURONS-1:0]       spike_in;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [c_IDX_W-1:0]         winner;
    logic [CNT_W-1:0]           winner_count;
    logic                       no_spike;
    logic [N_NEURONS*CNT_W-1:0] count_flat;
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
    logic [WIN_W-1:0]           first_spike_t;
`endif

    modport slave (
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
        output first_spike_t,
`endif
        input  start, window_len, spike_in, out_ready,
        output busy, out_valid, winner, winner_count, no_spike, count_flat
    );

    modport master (
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
        input  first_spike_t,
`endif
        output start, window_len, spike_in, out_ready,
        input  busy, out_valid, winner, winner_count, no_spike, count_flat
    );

endinterface
`default_nettype wire

// File: rtl/spike_window_decoder_spike_counter_sat.sv
`default_nettype none
// ============================================================================
// Module   : spike_counter_sat
// Purpose  : Per-neuron saturating spike counter with optional first-spike
//            timestamp (SPIKE_DECODER_FIRST_SPIKE_EN).
// Revision : 1.0
// ============================================================================
module spike_counter_sat
    import spike_decoder_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic             i_spike,
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
    input  wire logic [WIN_W-1:0] i_cycle,
    output logic      [WIN_W-1:0] o_first_t,
`endif
    output logic      [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && i_spike) begin
            r_count <= CNT_W'(sat_inc(32'(r_count), CNT_W));
        end
    end

    assign o_count = r_count;

`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
    logic             r_hit;
    logic [WIN_W-1:0] r_first_t;

    // All-ones marks "never spiked" so it loses every timestamp comparison.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_hit     <= 1'b0;
            r_first_t <= '1;
        end else if (i_en && i_spike && !r_hit) begin
            r_hit     <= 1'b1;
            r_first_t <= i_cycle;
        end
    end

    assign o_first_t = r_first_t;
`endif

endmodule
`default_nettype wire

// File: rtl/spike_window_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_window_decoder
// Purpose  : Counts spikes per neuron over a window, picks the most active one
//            and offers it on a valid/ready handshake. Optional macro:
//            SPIKE_DECODER_FIRST_SPIKE_EN (earliest-first-spike tie break).
// Revision : 1.0
// ============================================================================
module spike_window_decoder
    import spike_decoder_pkg::*;
#(
    parameter int N_NEURONS = 2,
    parameter int CNT_W     = 8,
    parameter int WIN_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    spike_window_decoder_if.slave  dec_if
);

    localparam int c_IDX_W  = idx_width(N_NEURONS);
    localparam int c_SCAN_W = $clog2(N_NEURONS + 1);

    state_t                     r_state;
    logic [WIN_W-1:0]           r_win_len;
    logic [WIN_W-1:0]           r_cyc;
    logic [c_SCAN_W-1:0]        r_scan_idx;
    logic [c_IDX_W-1:0]         r_best_idx;
    logic [CNT_W-1:0]           r_best_cnt;
    logic                       r_busy;
    logic                       r_out_valid;
    logic [c_IDX_W-1:0]         r_winner;
    logic [CNT_W-1:0]           r_winner_count;
    logic                       r_no_spike;
    logic [N_NEURONS*CNT_W-1:0] r_count_flat;

    logic                       w_clr;
    logic                       w_en;
    logic [CNT_W-1:0]           w_counts [N_NEURONS];
    logic [N_NEURONS*CNT_W-1:0] w_flat;
    logic [c_IDX_W-1:0]         w_sel_idx;
    logic                       w_better;

    assign w_clr = (r_state == ST_IDLE) && dec_if.start;
    assign w_en  = (r_state == ST_COUNT);

`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
    logic [WIN_W-1:0] w_first_t [N_NEURONS];
    logic [WIN_W-1:0] r_best_t;
    logic [WIN_W-1:0] r_first_spike_t;
`endif

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_counter
            spike_counter_sat #(
                .CNT_W (CNT_W),
                .WIN_W (WIN_W)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .i_clr     (w_clr),
                .i_en      (w_en),
                .i_spike   (dec_if.spike_in[gi]),
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
                .i_cycle   (r_cyc),
                .o_first_t (w_first_t[gi]),
`endif
                .o_count   (w_counts[gi])
            );
            assign w_flat[gi*CNT_W +: CNT_W] = w_counts[gi];
        end
    endgenerate

    assign w_sel_idx = r_scan_idx[c_IDX_W-1:0];

    // First candidate is always taken; later ones only if strictly better.
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
    assign w_better = (r_scan_idx == '0)
                   || (w_counts[w_sel_idx] > r_best_cnt)
                   || ((w_counts[w_sel_idx] == r_best_cnt) && (w_first_t[w_sel_idx] < r_best_t));
`else
    assign w_better = (r_scan_idx == '0) || (w_counts[w_sel_idx] > r_best_cnt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_win_len      <= '0;
            r_cyc          <= '0;
            r_scan_idx     <= '0;
            r_best_idx     <= '0;
            r_best_cnt     <= '0;
            r_busy         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_winner       <= '0;
            r_winner_count <= '0;
            r_no_spike     <= 1'b0;
            r_count_flat   <= '0;
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
            r_best_t        <= '1;
            r_first_spike_t <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dec_if.start) begin
                        r_win_len <= (dec_if.window_len == '0) ? WIN_W'(1) : dec_if.window_len;
                        r_cyc     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_cyc <= r_cyc + WIN_W'(1);
                    if (r_cyc == r_win_len - WIN_W'(1)) begin
                        r_scan_idx <= '0;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_scan_idx == c_SCAN_W'(N_NEURONS)) begin
                        r_winner       <= r_best_idx;
                        r_winner_count <= r_best_cnt;
                        r_no_spike     <= (r_best_cnt == '0);
                        r_count_flat   <= w_flat;
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
                        r_first_spike_t <= r_best_t;
`endif
                        r_out_valid    <= 1'b1;
                        r_state        <= ST_HOLD;
                    end else begin
                        if (w_better) begin
                            r_best_idx <= w_sel_idx;
                            r_best_cnt <= w_counts[w_sel_idx];
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
                            r_best_t   <= w_first_t[w_sel_idx];
`endif
                        end
                        r_scan_idx <= r_scan_idx + c_SCAN_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_out_valid && dec_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dec_if.busy         = r_busy;
    assign dec_if.out_valid    = r_out_valid;
    assign dec_if.winner       = r_winner;
    assign dec_if.winner_count = r_winner_count;
    assign dec_if.no_spike     = r_no_spike;
    assign dec_if.count_flat   = r_count_flat;
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
    assign dec_if.first_spike_t = r_first_spike_t;
`endif

endmodule
`default_nettype wire
